// File: rtl/instruction_issue_pipe.sv
// Issue register plus decode/execute/memory/writeback instruction registers.
// Obeys stall/flush from the hazard logic and exports every stage word.
module instruction_issue_pipe #(
   parameter logic [31:0] NOP_WORD    = 32'h0,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            instr_in,
   input  logic                   instr_in_valid,
   output logic                   instr_in_ready,
   input  logic                   stall,
   input  logic                   flush,
   output logic [31:0]            issue_reg_output,
   output logic [31:0]            decode_stage_instruction,
   output logic [31:0]            execute_stage_instruction,
   output logic [31:0]            memory_stage_instruction,
   output logic [31:0]            writeback_stage_instruction,
   output logic [COUNT_WIDTH-1:0] retired_count,
   output logic [COUNT_WIDTH-1:0] bubble_count
);

   logic [31:0]            issue_q, issue_d;
   logic [31:0]            decode_q, decode_d;
   logic [31:0]            execute_q, memory_q, writeback_q;
   logic [COUNT_WIDTH-1:0] retired_q, retired_d;
   logic [COUNT_WIDTH-1:0] bubble_q, bubble_d;
   logic                   handshake;

   assign instr_in_ready = !rst && !stall && !flush;
   assign handshake      = instr_in_valid && instr_in_ready;

   always_comb begin
      issue_d   = issue_q;
      decode_d  = decode_q;
      retired_d = retired_q;
      bubble_d  = bubble_q;

      // Flush beats stall; stall holds issue and bubbles decode.
      if (flush) begin
         issue_d  = NOP_WORD;
         decode_d = NOP_WORD;
      end else if (stall) begin
         decode_d = NOP_WORD;
      end else begin
         decode_d = issue_q;
         issue_d  = handshake ? instr_in : NOP_WORD;
      end

      if (memory_q != NOP_WORD && retired_q != {COUNT_WIDTH{1'b1}}) begin
         retired_d = retired_q + 1'b1;
      end

      // Only a stall that actually holds a real word counts as a bubble.
      if (stall && !flush && issue_q != NOP_WORD && bubble_q != {COUNT_WIDTH{1'b1}}) begin
         bubble_d = bubble_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         issue_q     <= NOP_WORD;
         decode_q    <= NOP_WORD;
         execute_q   <= NOP_WORD;
         memory_q    <= NOP_WORD;
         writeback_q <= NOP_WORD;
         retired_q   <= '0;
         bubble_q    <= '0;
      end else begin
         issue_q     <= issue_d;
         decode_q    <= decode_d;
         execute_q   <= decode_q;
         memory_q    <= execute_q;
         writeback_q <= memory_q;
         retired_q   <= retired_d;
         bubble_q    <= bubble_d;
      end
   end

   assign issue_reg_output            = issue_q;
   assign decode_stage_instruction    = decode_q;
   assign execute_stage_instruction   = execute_q;
   assign memory_stage_instruction    = memory_q;
   assign writeback_stage_instruction = writeback_q;
   assign retired_count               = retired_q;
   assign bubble_count                = bubble_q;

endmodule
